// File: rtl/imem_pkg.sv
// Shared types and constants for the program instruction memory.
// IMEM_PARITY_EN, when defined, adds one even-parity bit to every stored word.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
    localparam int          DEFAULT_DEPTH = 64;

    // The stored bit makes the total count of ones in {parity, word} even.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/prog_instr_mem_if.sv
// Loader handshake and fetch bus of the program instruction memory.
// The master side is the loader/PC; the slave side is the memory.
interface prog_instr_mem_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 7
);
    logic              ld_start;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [ADDR_W-1:0] address;
    logic [31:0]       instruction;
    logic              instr_valid;
    logic              fault;
    logic [CNT_W-1:0]  ld_count;
    logic              parity_err;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, address,
        input  ld_ready, instruction, instr_valid, fault, ld_count, parity_err
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, address,
        output ld_ready, instruction, instr_valid, fault, ld_count, parity_err
    );
endinterface

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// IMEM_PARITY_EN adds a parity lane that is checked on every read.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata,
    output logic             rpar_ok
);

`ifdef IMEM_PARITY_EN
    localparam int WORD_W = 33;
`else
    localparam int WORD_W = 32;
`endif

    // Contents are deliberately not reset; a full load defines them.
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] wword_s;
    logic [WORD_W-1:0] rword_s;

    // Build the stored word, with its parity bit when the lane exists.
    always_comb begin
`ifdef IMEM_PARITY_EN
        wword_s = {even_parity(wdata), wdata};
`else
        wword_s = wdata;
`endif
    end

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wword_s;
        end
    end

    // Asynchronous read port with parity recheck.
    always_comb begin
        rword_s = mem_q[raddr];
        rdata   = rword_s[31:0];
`ifdef IMEM_PARITY_EN
        rpar_ok = (^rword_s) == 1'b0;
`else
        rpar_ok = 1'b1;
`endif
    end

endmodule

// File: rtl/prog_instr_mem.sv
// Loadable program instruction memory with combinational, fault-checked fetch.
// IMEM_PARITY_EN enables per-word parity storage and checking.
module prog_instr_mem
    import imem_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    prog_instr_mem_if.slave     bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_s;
    logic [ADDR_W-3:0] idx_s;
    logic              legal_s;
    logic [31:0]       rdata_s;
    logic              rpar_ok_s;

    // Load FSM next-state; a start request always wins over a data beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ld_start) begin
                    state_d = LOAD;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (bus.ld_start) begin
                    state_d = LOAD;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (bus.ld_valid) begin
                    we_s  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.ld_last || (cnt_q == CNT_W'(DEPTH - 1))) begin
                        state_d = RUN;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (bus.ld_start) begin
                    state_d = LOAD;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and loaded-word count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we      (we_s),
        .waddr   (cnt_q[IDX_W-1:0]),
        .wdata   (bus.ld_data),
        .raddr   (idx_s[IDX_W-1:0]),
        .rdata   (rdata_s),
        .rpar_ok (rpar_ok_s)
    );

    // Full-width index compare so high addresses never alias low words.
    always_comb begin
        idx_s   = bus.address[ADDR_W-1:2];
        legal_s = (bus.address[1:0] == 2'b00)
                  && (idx_s < (ADDR_W-2)'(cnt_q))
                  && (idx_s < (ADDR_W-2)'(DEPTH));
    end

    // Fetch response; only RUN can return a word or raise a fault.
    always_comb begin
        bus.instruction = NOP_WORD;
        bus.instr_valid = 1'b0;
        bus.fault       = 1'b0;
        bus.parity_err  = 1'b0;
        if (state_q == RUN) begin
            if (!legal_s) begin
                bus.fault = 1'b1;
            end else if (!rpar_ok_s) begin
                bus.fault      = 1'b1;
                bus.parity_err = 1'b1;
            end else begin
                bus.instruction = rdata_s;
                bus.instr_valid = 1'b1;
            end
        end else begin
            bus.fault = 1'b0;
        end
    end

    assign bus.ld_ready = (state_q == LOAD);
    assign bus.ld_count = cnt_q;

endmodule

// File: tb/tb_prog_instr_mem.sv
// Self-checking bench for prog_instr_mem: a DEPTH=64 and a DEPTH=4 instance.
module tb_prog_instr_mem;
    import imem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_instr_mem_if #(.ADDR_W(32), .CNT_W(7)) bus  ();
    prog_instr_mem_if #(.ADDR_W(32), .CNT_W(3)) bus4 ();

    prog_instr_mem #(.DEPTH(64), .ADDR_W(32), .CNT_W(7)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    prog_instr_mem #(.DEPTH(4),  .ADDR_W(32), .CNT_W(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
    } fvec_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic        perr;
    } exp_t;

    int    n_vec = 0;
    int    n_err = 0;
    exp_t  sbq[$];
    fvec_t tbl[11];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock of loader stimulus on either instance, then idle the inputs.
    task automatic drive_cycle(input bit d4, input logic st, input logic vl,
                               input logic [31:0] dat, input logic lst);
        if (d4) begin
            bus4.ld_start = st; bus4.ld_valid = vl; bus4.ld_data = dat; bus4.ld_last = lst;
        end else begin
            bus.ld_start = st; bus.ld_valid = vl; bus.ld_data = dat; bus.ld_last = lst;
        end
        @(posedge clk);
        #1;
        bus.ld_start = 1'b0;  bus.ld_valid = 1'b0;  bus.ld_last = 1'b0;
        bus4.ld_start = 1'b0; bus4.ld_valid = 1'b0; bus4.ld_last = 1'b0;
    endtask

    task automatic fetch_check(input bit d4, input string nm, input logic [31:0] addr,
                               input logic [31:0] e_instr, input logic e_valid,
                               input logic e_fault, input logic e_perr);
        exp_t e;
        if (d4) bus4.address = addr;
        else    bus.address  = addr;
        sbq.push_back('{nm, e_instr, e_valid, e_fault, e_perr});
        @(negedge clk);
        e = sbq.pop_front();
        if (d4) begin
            cmp({e.name, ".instr"}, 64'(bus4.instruction), 64'(e.instr));
            cmp({e.name, ".valid"}, 64'(bus4.instr_valid), 64'(e.valid));
            cmp({e.name, ".fault"}, 64'(bus4.fault),       64'(e.fault));
            cmp({e.name, ".perr"},  64'(bus4.parity_err),  64'(e.perr));
        end else begin
            cmp({e.name, ".instr"}, 64'(bus.instruction),  64'(e.instr));
            cmp({e.name, ".valid"}, 64'(bus.instr_valid),  64'(e.valid));
            cmp({e.name, ".fault"}, 64'(bus.fault),        64'(e.fault));
            cmp({e.name, ".perr"},  64'(bus.parity_err),   64'(e.perr));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'h0000_0000, 32'h8E08_0000, 1'b1, 1'b0};
        tbl[1]  = '{32'h0000_0004, 32'h0100_8820, 1'b1, 1'b0};
        tbl[2]  = '{32'h0000_0008, 32'hAE11_0028, 1'b1, 1'b0};
        tbl[3]  = '{32'h0000_000C, 32'h0000_0000, 1'b0, 1'b1};
        tbl[4]  = '{32'h0000_0006, 32'h0000_0000, 1'b0, 1'b1};
        tbl[5]  = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
        tbl[6]  = '{32'h0000_0003, 32'h0000_0000, 1'b0, 1'b1};
        tbl[7]  = '{32'h0000_0100, 32'h0000_0000, 1'b0, 1'b1};
        tbl[8]  = '{32'h0000_0104, 32'h0000_0000, 1'b0, 1'b1};
        tbl[9]  = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1};
        tbl[10] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1};

        bus.ld_start = 1'b0;  bus.ld_valid = 1'b0;  bus.ld_data = 32'h0;  bus.ld_last = 1'b0;  bus.address = 32'h0;
        bus4.ld_start = 1'b0; bus4.ld_valid = 1'b0; bus4.ld_data = 32'h0; bus4.ld_last = 1'b0; bus4.address = 32'h0;

        // Reset state, with a start request held to show reset dominates.
        bus.ld_start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst.state", 64'(dut.state_q), 64'(IDLE));
        cmp("rst.count", 64'(bus.ld_count), 64'd0);
        cmp("rst.ready", 64'(bus.ld_ready), 64'd0);
        fetch_check(1'b0, "rst.fetch0", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.ld_start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fetch_check(1'b0, "idle.fetch0", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Basic three-word load.
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cmp("ld.start.count", 64'(bus.ld_count), 64'd0);
        cmp("ld.start.ready", 64'(bus.ld_ready), 64'd1);
        fetch_check(1'b0, "load.fetch0", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h8E08_0000, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0100_8820, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'hAE11_0028, 1'b1);
        cmp("ld.state", 64'(dut.state_q), 64'(RUN));
        cmp("ld.count", 64'(bus.ld_count), 64'd3);
        cmp("ld.ready", 64'(bus.ld_ready), 64'd0);

        // Data beats in RUN are ignored.
        drive_cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        cmp("run.ignore.count", 64'(bus.ld_count), 64'd3);

        for (int i = 0; i < 11; i++) begin
            fetch_check(1'b0, $sformatf("tbl%0d", i), tbl[i].addr, tbl[i].instr,
                        tbl[i].valid, tbl[i].fault, 1'b0);
        end

        // Backpressure gap, then restart colliding with a data beat.
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h2222_2222, 1'b0);
        cmp("gap.count", 64'(bus.ld_count), 64'd1);
        cmp("gap.ready", 64'(bus.ld_ready), 64'd1);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h3333_3333, 1'b0);
        cmp("gap.count2", 64'(bus.ld_count), 64'd2);
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h4444_4444, 1'b1);
        cmp("restart.count", 64'(bus.ld_count), 64'd0);
        cmp("restart.state", 64'(dut.state_q), 64'(LOAD));
        drive_cycle(1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h5A5A_0002, 1'b1);
        cmp("restart.final", 64'(bus.ld_count), 64'd2);
        fetch_check(1'b0, "restart.w0", 32'h0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
        fetch_check(1'b0, "restart.w1", 32'h4, 32'h5A5A_0002, 1'b1, 1'b0, 1'b0);
        fetch_check(1'b0, "restart.w2", 32'h8, 32'h0, 1'b0, 1'b1, 1'b0);

`ifdef IMEM_PARITY_EN
        // Corrupt one data bit of word 0 while keeping its old parity bit.
        force dut.u_array.mem_q[0] = {even_parity(32'hA5A5_0001), 32'hA5A5_0000};
        fetch_check(1'b0, "parity.w0", 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        fetch_check(1'b0, "parity.w1", 32'h4, 32'h5A5A_0002, 1'b1, 1'b0, 1'b0);
        release dut.u_array.mem_q[0];
`endif

        // DEPTH=4 instance: load ends after word 3 without ld_last.
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b1, 32'hC000_0000 + 32'(i), 1'b0);
        end
        cmp("d4.count", 64'(bus4.ld_count), 64'd4);
        cmp("d4.ready", 64'(bus4.ld_ready), 64'd0);
        cmp("d4.state", 64'(dut4.state_q), 64'(RUN));
        fetch_check(1'b1, "d4.w0",  32'h0,  32'hC000_0000, 1'b1, 1'b0, 1'b0);
        fetch_check(1'b1, "d4.w3",  32'hC,  32'hC000_0003, 1'b1, 1'b0, 1'b0);
        fetch_check(1'b1, "d4.a16", 32'h10, 32'h0,         1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a load.
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h7777_0000, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h7777_0001, 1'b0);
        cmp("midrst.pre", 64'(bus.ld_count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("midrst.state", 64'(dut.state_q), 64'(IDLE));
        cmp("midrst.count", 64'(bus.ld_count), 64'd0);
        cmp("midrst.ready", 64'(bus.ld_ready), 64'd0);
        fetch_check(1'b0, "midrst.fetch0", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h9999_9999, 1'b1);
        cmp("postrst.state", 64'(dut.state_q), 64'(IDLE));
        fetch_check(1'b0, "postrst.fetch0", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_instr_mem.md
PROG_INSTR_MEM -- requirements
Module: prog_instr_mem

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit instruction words stored.
REQ-002 Parameter ADDR_W, default 32: width of the byte fetch address.
REQ-003 Parameter CNT_W, default $clog2(DEPTH+1): width of the loaded-word count.
REQ-004 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port ld_start, input, 1: one-cycle request to begin a program load.
REQ-008 Port ld_valid, input, 1: ld_data holds a valid instruction word.
REQ-009 Port ld_data, input, 32: instruction word to store.
REQ-010 Port ld_last, input, 1: qualifies the final word of the load.
REQ-011 Port ld_ready, output, 1: the block accepts ld_data this cycle.
REQ-012 Port address, input, ADDR_W: byte fetch address from the PC.
REQ-013 Port instruction, output, 32: fetched word, big-endian byte order.
REQ-014 Port instr_valid, output, 1: instruction is legal and from a loaded word.
REQ-015 Port fault, output, 1: fetch is misaligned, out of range, or beyond the loaded count.
REQ-016 Port ld_count, output, CNT_W: number of words written by the last or current load.
REQ-017 Port parity_err, output, 1: stored word failed its parity check.

Function
REQ-018 FSM states are IDLE, LOAD and RUN; reset state is IDLE.
REQ-019 IDLE to LOAD on ld_start; ld_count is cleared to 0 on that edge.
REQ-020 In LOAD, ld_ready=1; ld_valid&ld_ready writes ld_data to word ld_count and increments ld_count.
REQ-021 LOAD to RUN on an accepted word with ld_last=1, or on acceptance of word DEPTH-1, whichever comes first.
REQ-022 ld_ready=0 in IDLE and RUN; in those states ld_valid is ignored and memory is unchanged.
REQ-023 ld_start in LOAD or RUN restarts: ld_count cleared to 0, state LOAD; ld_start wins over a same-cycle ld_valid, and that word is dropped.
REQ-024 Fetch is combinational, with zero-cycle latency from address to instruction, as required by the single-cycle datapath.
REQ-025 Word index = address[ADDR_W-1:2]; byte at address+0 maps to instruction[31:24].
REQ-026 In RUN, a fetch is legal when address[1:0]==0 and word index < ld_count; legal fetches drive instr_valid=1, fault=0 and the stored word.
REQ-027 Illegal fetch in RUN: instruction=32'h0 (NOP), instr_valid=0, fault=1.
REQ-028 In IDLE or LOAD: instruction=32'h0, instr_valid=0, fault=0.
REQ-029 The word index never wraps; an index >= DEPTH always faults.

Reset
REQ-030 While rst_n=0: state=IDLE, ld_count=0, ld_ready=0, instruction=0, instr_valid=0, fault=0, parity_err=0.
REQ-031 The storage array is not reset; an assertion mid-LOAD aborts the load, and the contents are untrusted until the next full load.

Configuration
REQ-032 When macro IMEM_PARITY_EN is defined, each word stores an even-parity bit computed at write time.
REQ-033 With IMEM_PARITY_EN defined, parity is rechecked on each legal fetch; on mismatch, parity_err=1, instr_valid=0 and fault=1.
REQ-034 Without IMEM_PARITY_EN, no parity bit is stored and parity_err is tied to 0.

Structure
REQ-035 Package imem_pkg holds: the state enum (IDLE/LOAD/RUN), localparam NOP_WORD=32'h0, and DEFAULT_DEPTH=64.
REQ-036 Storage is a sub-module imem_array with one synchronous write port, one asynchronous read port, and optional parity lane.

Verification
REQ-037 Load test: reset, ld_start, then 3 words 0x8E080000, 0x01008820, 0xAE110028, the last with ld_last=1 -> state RUN, ld_count=3.
REQ-038 Fetch test: after REQ-037, address=4 -> instruction=0x01008820, instr_valid=1; address=12 -> fault=1, instruction=0.
REQ-039 Misaligned and range: address=6 -> fault=1; a DEPTH=4 load with no ld_last ends after word 3, ld_ready=0, and address=16 -> fault=1.
REQ-040 Backpressure and restart: ld_valid gaps are tolerated; ld_start with ld_valid in the same cycle mid-load -> ld_count=0 and the word is dropped.
REQ-041 Reset mid-LOAD after 2 words: rst_n=0 -> state IDLE, ld_count=0, and fetch at 0 -> instr_valid=0.
REQ-042 Parity (IMEM_PARITY_EN defined): force-flip one stored bit of word 0, then fetch address 0 -> parity_err=1, fault=1.
